dff_bist_checker: RTL and testbench

Built-in self-test engine for single-bit storage elements such as `d_flip_flop`. It drives a pseudo-random bit stream onto the element's `d` input and reads back `q` and `q_bar` after a programmable pipeline latency. It counts mismatches and reports pass/fail with a start/done handshake. It is the checking end of the flip-flop interface: the hardware counterpart of a stimulus bench, used for on-chip sign-off of storage cells.

---
 rtl/dff_bist_pkg.sv | 23 ++
 rtl/bist_lfsr.sv | 28 ++
 rtl/dff_bist_checker.sv | 140 ++++++++++++++
 tb/tb_dff_bist_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dff_bist_pkg.sv
// Shared types and constants for the flip-flop BIST checker.
package dff_bist_pkg;

  localparam int LFSR_W = 8;

  // Feedback taps: bits 0, 2, 3 and 4 of the Fibonacci register.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'b0001_1101;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
    return (s == '0) ? DEFAULT_SEED : s;
  endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 8-bit Fibonacci LFSR stimulus source with load, enable and zero-seed substitution.
module bist_lfsr
  import dff_bist_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [LFSR_W-1:0] seed,
  output logic              bit_out
);

  logic [LFSR_W-1:0] lfsr;

  // Load on run start, otherwise shift right with parity feedback into the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr <= DEFAULT_SEED;
    end else if (load) begin
      lfsr <= seed_fix(seed);
    end else if (en) begin
      lfsr <= {^(lfsr & LFSR_TAPS), lfsr[LFSR_W-1:1]};
    end
  end

  assign bit_out = lfsr[0];

endmodule

// File: rtl/dff_bist_checker.sv
// BIST engine for single-bit storage cells: drives a pseudo-random stream,
// compares the delayed read-back against an expected-bit pipeline and
// reports a saturating error count with a start/done handshake.
module dff_bist_checker
  import dff_bist_pkg::*;
#(
  parameter int NUM_VEC = 64,
  parameter int LATENCY = 1,
  parameter int ERR_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LFSR_W-1:0] seed,
  output logic              d_out,
  input  logic              q_in,
  input  logic              q_bar_in,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count
);

  localparam int VEC_W = $clog2(NUM_VEC + 1);
  localparam int DRN_W = $clog2(LATENCY + 1);
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VEC - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(LATENCY - 1);

  state_t            state_q;
  state_t            state_d;
  logic              accept;
  logic              lfsr_en;
  logic              lfsr_bit;
  logic [VEC_W-1:0]  vec_cnt;
  logic [DRN_W-1:0]  drn_cnt;
  logic [LATENCY-1:0] vld_p;
  logic [LATENCY-1:0] exp_p;
  logic              chk_err;
  logic [ERR_W-1:0]  err_next;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  bist_lfsr u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load    (accept),
    .en      (lfsr_en),
    .seed    (seed),
    .bit_out (lfsr_bit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start is only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    lfsr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          accept  = 1'b1;
        end
      end
      ST_RUN: begin
        lfsr_en = 1'b1;
        if (vec_cnt == VEC_LAST) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drn_cnt == DRN_LAST) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Vector counter over RUN and drain counter over DRAIN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec_cnt <= '0;
      drn_cnt <= '0;
    end else begin
      if (accept)                 vec_cnt <= '0;
      else if (state_q == ST_RUN) vec_cnt <= vec_cnt + 1'b1;
      if (state_q == ST_RUN)        drn_cnt <= '0;
      else if (state_q == ST_DRAIN) drn_cnt <= drn_cnt + 1'b1;
    end
  end

  assign d_out = (state_q == ST_RUN) & lfsr_bit;
  assign busy  = (state_q == ST_RUN) | (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);

  // Stage p0..p(LATENCY-1): valid flags track which cycles carried real vectors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= (state_q == ST_RUN);
      for (int i = 1; i < LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  // Stage p0..p(LATENCY-1): expected bits ride alongside their valid flags.
  always_ff @(posedge clk) begin
    exp_p[0] <= d_out;
    for (int i = 1; i < LATENCY; i++) exp_p[i] <= exp_p[i-1];
  end

  // Compare stage: wrong q or non-complementary q_bar counts as one error.
  always_comb begin
    chk_err  = vld_p[LATENCY-1] &
               ((q_in != exp_p[LATENCY-1]) | (q_bar_in == q_in));
    err_next = err_count;
    if (accept)       err_next = '0;
    else if (chk_err) err_next = sat_inc(err_count);
  end

  // Error counter and pass flag; pass is resolved on the final check edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_count <= '0;
      pass      <= 1'b0;
    end else begin
      err_count <= err_next;
      if (accept)
        pass <= 1'b0;
      else if ((state_q == ST_DRAIN) && (state_d == ST_DONE))
        pass <= (err_next == '0);
    end
  end

endmodule

// File: tb/tb_dff_bist_checker.sv
// Bench for dff_bist_checker: two instances (16 vectors / latency 1 / 8-bit
// count and 20 vectors / latency 3 / 4-bit count) each wired to a behavioural
// storage cell whose q and q_bar can be corrupted cycle by cycle.
module tb_dff_bist_checker;

  localparam int NA = 16, LA = 1, EA = 8;
  localparam int NB = 20, LB = 3, EB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic start_a = 1'b0, start_b = 1'b0;
  logic [7:0] seed_a = 8'h00, seed_b = 8'h00;
  logic qx_a = 1'b0, bx_a = 1'b0, qx_b = 1'b0, bx_b = 1'b0;

  wire d_a, busy_a, done_a, pass_a;
  wire d_b, busy_b, done_b, pass_b;
  wire [EA-1:0] err_a;
  wire [EB-1:0] err_b;

  // Behavioural storage cells: pure delay of d, then optional corruption.
  logic dly_a = 1'b0;
  logic [LB-1:0] dly_b = '0;
  always @(posedge clk) begin
    dly_a <= d_a;
    dly_b <= {dly_b[LB-2:0], d_b};
  end
  wire q_a  = dly_a ^ qx_a;
  wire qb_a = ~q_a ^ bx_a;
  wire q_b  = dly_b[LB-1] ^ qx_b;
  wire qb_b = ~q_b ^ bx_b;

  dff_bist_checker #(.NUM_VEC(NA), .LATENCY(LA), .ERR_W(EA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .seed(seed_a), .d_out(d_a),
    .q_in(q_a), .q_bar_in(qb_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a));

  dff_bist_checker #(.NUM_VEC(NB), .LATENCY(LB), .ERR_W(EB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .seed(seed_b), .d_out(d_b),
    .q_in(q_b), .q_bar_in(qb_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference stimulus: the spec's LFSR rule in plain integer arithmetic.
  bit ref_seq[$];
  function automatic void gen_seq(input logic [7:0] sd, input int n);
    int s, fb;
    s = (sd == 8'h00) ? 1 : int'(sd);
    ref_seq.delete();
    for (int i = 0; i < n; i++) begin
      ref_seq.push_back(bit'(s & 1));
      fb = (s ^ (s >> 2) ^ (s >> 3) ^ (s >> 4)) & 1;
      s  = (s >> 1) | (fb << 7);
    end
  endfunction

  bit run_d[$];
  bit saved_d[$];

  // One complete run on instance sel. Modes: 0 clean, 1 q=~d q_bar=d,
  // 2 q_bar tied to q, 3 q always wrong, 4 random corruption.
  // Unchecked cycles always get random corruption, which must not count.
  task automatic run_bist(input int sel, input logic [7:0] sd, input int mode,
                          input int tab_err, input int tab_pass, input bit hold,
                          input string name);
    int n, l, emax, model_err, exp_err, exp_pass;
    int d_bad, busy_bad, done_cnt, done_at, fin_err, fin_pass, held_err;
    bit fq, fb, cd, cb, cdn, exp_d, exp_busy;
    int ce, cp;
    n = sel ? NB : NA;
    l = sel ? LB : LA;
    emax = sel ? ((1 << EB) - 1) : ((1 << EA) - 1);
    gen_seq(sd, n);
    run_d.delete();
    model_err = 0; d_bad = 0; busy_bad = 0; done_cnt = 0; done_at = -1;
    fin_err = -1; fin_pass = -1; held_err = -1;
    @(negedge clk);
    if (sel) begin seed_b = sd; start_b = 1'b1; end
    else     begin seed_a = sd; start_a = 1'b1; end
    for (int c = 1; c <= n + l + 3; c++) begin
      @(negedge clk);
      if (!hold) begin start_a = 1'b0; start_b = 1'b0; end
      if (c >= l + 1 && c <= n + l) begin
        case (mode)
          0: begin fq = 1'b0; fb = 1'b0; end
          1: begin fq = 1'b1; fb = 1'b0; end
          2: begin fq = 1'b0; fb = 1'b1; end
          3: begin fq = 1'b1; fb = 1'($urandom); end
          default: begin
            fq = ($urandom_range(0, 3) == 0);
            fb = ($urandom_range(0, 4) == 0);
          end
        endcase
        if (fq | fb) model_err++;
      end else begin
        fq = 1'($urandom);
        fb = 1'($urandom);
      end
      if (sel) begin qx_b = fq; bx_b = fb; end
      else     begin qx_a = fq; bx_a = fb; end
      cd  = sel ? d_b : d_a;
      cb  = sel ? busy_b : busy_a;
      cdn = sel ? done_b : done_a;
      ce  = sel ? int'(err_b) : int'(err_a);
      cp  = sel ? int'(pass_b) : int'(pass_a);
      if (c <= n)                       exp_d = ref_seq[c-1];
      else if (hold && c == n + l + 3)  exp_d = ref_seq[0];
      else                              exp_d = 1'b0;
      if (cd != exp_d) d_bad++;
      if (c <= n) run_d.push_back(cd);
      exp_busy = (c <= n + l) || (hold && c == n + l + 3);
      if (cb != exp_busy) busy_bad++;
      if (cdn) begin done_cnt++; done_at = c; end
      if (c == n + l + 1) begin fin_err = ce; fin_pass = cp; end
      if (c == n + l + 3) held_err = ce;
    end
    exp_err  = (tab_err >= 0) ? tab_err : ((model_err > emax) ? emax : model_err);
    exp_pass = (tab_pass >= 0) ? tab_pass : ((exp_err == 0) ? 1 : 0);
    chk({name, " d_out_seq_bad"}, d_bad, 0);
    chk({name, " busy_bad"}, busy_bad, 0);
    chk({name, " done_pulses"}, done_cnt, 1);
    chk({name, " done_cycle"}, done_at, n + l + 1);
    chk({name, " err_count"}, fin_err, exp_err);
    chk({name, " pass"}, fin_pass, exp_pass);
    if (!hold) chk({name, " err_held"}, held_err, exp_err);
  endtask

  typedef struct {
    int sel;
    logic [7:0] seed;
    int mode;
    int exp_err;
    int exp_pass;
    string name;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{0, 8'h01, 0,  0, 1, "a_good"};
    tbl[1] = '{0, 8'h01, 1, 16, 0, "a_inverted"};
    tbl[2] = '{0, 8'h3C, 2, 16, 0, "a_qbar_tied"};
    tbl[3] = '{1, 8'h01, 0,  0, 1, "b_lat3_seed01"};
    tbl[4] = '{1, 8'h00, 0,  0, 1, "b_lat3_seed00"};
    tbl[5] = '{1, 8'hA5, 3, 15, 0, "b_saturate"};

    // Reset state, checked while reset is asserted.
    #1;
    chk("rst busy_a", busy_a, 0);
    chk("rst done_a", done_a, 0);
    chk("rst pass_a", pass_a, 0);
    chk("rst err_a", err_a, 0);
    chk("rst d_a", d_a, 0);
    chk("rst busy_b", busy_b, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_bist(tbl[i].sel, tbl[i].seed, tbl[i].mode, tbl[i].exp_err,
               tbl[i].exp_pass, 1'b0, tbl[i].name);
      if (i == 3) saved_d = run_d;
      if (i == 4) begin
        int diff = 0;
        for (int j = 0; j < NB; j++) if (run_d[j] != saved_d[j]) diff++;
        chk("seed00_vs_seed01 diff", diff, 0);
      end
    end

    // Randomized runs against the reference model.
    for (int r = 0; r < 6; r++) begin
      run_bist(int'($urandom_range(0, 1)), 8'($urandom), 4, -1, -1, 1'b0,
               $sformatf("random%0d", r));
    end

    // Reset in cycle k+5 of a run with a wrong cell.
    @(negedge clk);
    seed_a = 8'h5A; start_a = 1'b1; qx_a = 1'b1; bx_a = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
    chk("midrun err_before_rst", err_a, 3);
    #1;
    rst = 1'b1;
    #1;
    chk("midrun busy_a", busy_a, 0);
    chk("midrun d_a", d_a, 0);
    chk("midrun err_a", err_a, 0);
    chk("midrun done_a", done_a, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    begin
      int stale = 0;
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (done_a || err_a != 0 || busy_a) stale++;
      end
      chk("after_rst stale", stale, 0);
    end
    qx_a = 1'b0;
    run_bist(0, 8'h5A, 0, 0, 1, 1'b0, "after_rst_run");

    // Start held high through the whole run: one run, next accepted at k+19.
    run_bist(0, 8'hC3, 0, 0, 1, 1'b1, "held_start");
    start_a = 1'b0;
    begin
      int t = 0;
      while (!done_a && t < 100) begin
        @(negedge clk);
        t++;
      end
      chk("held_start second_run_done", (t < 100) ? 1 : 0, 1);
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
